// File: rtl/eth_decap_if.sv
// rtl/eth_decap_if.sv - AXI4-Stream receive beat bundle between the 10G MAC and the decapsulator
interface eth_decap_if;
  logic        tvalid;
  logic        tready;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tlast;
  logic        tuser;

  modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/eth_decap.sv
// rtl/eth_decap.sv - strips the 48B Eth/IPv4/UDP encap header, filters frames, writes payload beats to the TLP FIFO
module eth_decap #(
  parameter logic [47:0] eth_addr  = 48'h00_11_22_33_44_55,
  parameter logic [31:0] ip_daddr  = {8'd192, 8'd168, 8'd1, 8'd122},
  parameter logic [15:0] udp_dport = 16'd3776,
  parameter int          hdr_beats = 6
) (
  input  logic        clk156,
  input  logic        sys_rst_n,
  eth_decap_if.slave  s_axis,
  output logic        wr_en,
  output logic [73:0] din,
  input  logic        full,
  output logic [31:0] pkt_ok_cnt,
  output logic [31:0] pkt_drop_cnt
);

  typedef enum logic [1:0] {RX_HDR, RX_DATA, RX_DROP} state_t;

  // Wire byte 0 sits in the LSB lane, so the MAC as it appears on tdata is byte-reversed.
  localparam logic [47:0] mac_lanes = {eth_addr[7:0], eth_addr[15:8], eth_addr[23:16],
                                       eth_addr[31:24], eth_addr[39:32], eth_addr[47:40]};
  localparam logic [2:0]  last_hdr  = 3'(hdr_beats - 1);

  state_t      state_q, state_d;
  logic [2:0]  hdr_cnt_q, hdr_cnt_d;
  logic        match_q, match_d;
  logic [31:0] ok_cnt_q, ok_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  logic        rdy;
  logic        accept;
  logic        beat_ok;
  logic [63:0] td;

  assign td = s_axis.tdata;

  always_comb begin
    rdy = 1'b1;
    if (state_q == RX_DATA) rdy = ~full;
    rdy = rdy & sys_rst_n;
  end

  assign accept        = s_axis.tvalid & rdy;
  assign s_axis.tready = rdy;

  always_comb begin
    beat_ok = 1'b1;
    case (hdr_cnt_q)
      3'd0: beat_ok = (td[47:0] == mac_lanes) || (td[47:0] == 48'hFFFF_FFFF_FFFF);
      3'd1: beat_ok = (td[39:32] == 8'h08) && (td[47:40] == 8'h00) && (td[55:48] == 8'h45);
      3'd2: beat_ok = (td[63:56] == 8'h11);
      3'd3: beat_ok = (td[55:48] == ip_daddr[31:24]) && (td[63:56] == ip_daddr[23:16]);
      3'd4: beat_ok = (td[7:0] == ip_daddr[15:8]) && (td[15:8] == ip_daddr[7:0]) &&
                      (td[39:32] == udp_dport[15:8]) && (td[47:40] == udp_dport[7:0]);
      default: beat_ok = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    match_d    = match_q;
    ok_cnt_d   = ok_cnt_q;
    drop_cnt_d = drop_cnt_q;
    wr_en      = 1'b0;
    din        = '0;
    case (state_q)
      RX_HDR: begin
        if (accept) begin
          if (s_axis.tlast) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
            hdr_cnt_d  = '0;
            match_d    = 1'b1;
          end else if (hdr_cnt_q == last_hdr) begin
            state_d   = (match_q & beat_ok & ~s_axis.tuser) ? RX_DATA : RX_DROP;
            hdr_cnt_d = '0;
            match_d   = 1'b1;
          end else begin
            hdr_cnt_d = hdr_cnt_q + 3'd1;
            match_d   = match_q & beat_ok & ~s_axis.tuser;
          end
        end
      end
      RX_DATA: begin
        wr_en = accept;
        if (sys_rst_n) din = {s_axis.tkeep, s_axis.tdata, s_axis.tlast, s_axis.tuser};
        if (accept && s_axis.tlast) begin
          ok_cnt_d = ok_cnt_q + 32'd1;
          state_d  = RX_HDR;
        end
      end
      RX_DROP: begin
        if (accept && s_axis.tlast) begin
          drop_cnt_d = drop_cnt_q + 32'd1;
          state_d    = RX_HDR;
        end
      end
      default: state_d = RX_HDR;
    endcase
  end

  always_ff @(posedge clk156 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= RX_HDR;
      hdr_cnt_q  <= '0;
      match_q    <= 1'b1;
      ok_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      match_q    <= match_d;
      ok_cnt_q   <= ok_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pkt_ok_cnt   = ok_cnt_q;
  assign pkt_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_eth_decap.sv
// tb/tb_eth_decap.sv - randomized frame-level bench for eth_decap with a byte-offset reference model
module tb_eth_decap;
  localparam logic [47:0] MAC   = 48'h00_11_22_33_44_55;
  localparam logic [31:0] IPD   = {8'd192, 8'd168, 8'd1, 8'd122};
  localparam logic [15:0] DPORT = 16'd3776;

  logic        clk156 = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        wr_en;
  logic [73:0] din;
  logic        full = 1'b0;
  logic [31:0] ok_cnt, drop_cnt;

  always #5 clk156 = ~clk156;

  eth_decap_if s_axis();

  eth_decap dut (
    .clk156       (clk156),
    .sys_rst_n    (sys_rst_n),
    .s_axis       (s_axis),
    .wr_en        (wr_en),
    .din          (din),
    .full         (full),
    .pkt_ok_cnt   (ok_cnt),
    .pkt_drop_cnt (drop_cnt)
  );

  logic [7:0]  fb[$];
  logic        fu[$];
  logic [73:0] exp_q[$];
  int          exp_ok = 0, exp_drop = 0;
  int          n_cmp = 0, n_bad = 0, n_wr = 0;
  int          tr_mode = 0;  // 0: not checked, 1: tready must be 1, 2: tready must be ~full
  bit          rand_full = 0, gaps = 0;

  task automatic chk(input string nm, input logic [73:0] act, input logic [73:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
    end
  endtask

  // Frames are built as plain byte streams; header fields live at fixed byte offsets.
  task automatic build_frame(input int kind, input int plen);
    logic [7:0]  h[48];
    logic [47:0] mac;
    logic [31:0] ip;
    int          nb;
    mac = MAC;
    ip  = IPD;
    fb.delete();
    fu.delete();
    for (int i = 0; i < 48; i++) h[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 6; i++) h[i] = mac[47-8*i -: 8];
    h[12] = 8'h08; h[13] = 8'h00; h[14] = 8'h45; h[23] = 8'h11;
    for (int i = 0; i < 4; i++) h[30+i] = ip[31-8*i -: 8];
    h[36] = DPORT[15:8]; h[37] = DPORT[7:0];
    case (kind)
      1: for (int i = 0; i < 6; i++) h[i] = 8'hFF;
      2: h[5] = 8'h56;
      3: h[13] = 8'h06;
      4: h[14] = 8'h46;
      5: h[23] = 8'h06;
      6: h[33] = h[33] ^ 8'(1 << $urandom_range(0, 7));
      7: h[37] = 8'hC1;
      default: ;
    endcase
    for (int i = 0; i < 48; i++) fb.push_back(h[i]);
    if (kind == 10) begin
      while (fb.size() > plen) void'(fb.pop_back());
    end else begin
      for (int i = 0; i < plen; i++) fb.push_back(8'($urandom_range(0, 255)));
    end
    nb = (fb.size() + 7) / 8;
    for (int i = 0; i < nb; i++) fu.push_back(1'b0);
    if (kind == 8) fu[$urandom_range(0, 5)] = 1'b1;
    if (kind == 9) fu[$urandom_range(6, nb - 1)] = 1'b1;
  endtask

  function automatic logic [63:0] beat_data(input int i);
    logic [63:0] d;
    for (int n = 0; n < 8; n++) d[8*n +: 8] = (8*i + n < fb.size()) ? fb[8*i + n] : 8'hA5;
    return d;
  endfunction

  function automatic logic [7:0] beat_keep(input int i);
    logic [7:0] k;
    for (int n = 0; n < 8; n++) k[n] = (8*i + n < fb.size());
    return k;
  endfunction

  function automatic bit model_fwd();
    logic [47:0] dst;
    logic [31:0] ip;
    logic [15:0] dp;
    bit          ok;
    if (fb.size() <= 48) return 1'b0;
    dst = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
    ip  = {fb[30], fb[31], fb[32], fb[33]};
    dp  = {fb[36], fb[37]};
    ok  = (dst == MAC) || (dst == 48'hFFFF_FFFF_FFFF);
    ok  = ok && fb[12] == 8'h08 && fb[13] == 8'h00 && fb[14] == 8'h45 && fb[23] == 8'h11;
    ok  = ok && ip == IPD && dp == DPORT;
    for (int b = 0; b < 6; b++) if (fu[b]) ok = 1'b0;
    return ok;
  endfunction

  task automatic push_expected();
    int nb;
    nb = fu.size();
    if (model_fwd())
      for (int i = 6; i < nb; i++)
        exp_q.push_back({beat_keep(i), beat_data(i), (i == nb - 1), fu[i]});
  endtask

  // Entered and left at posedge+1; the model counter moves once the final accept edge has passed.
  task automatic send_frame(input int stall_at, input int rst_at);
    bit fwd;
    bit acc;
    int nb, cyc;
    fwd = model_fwd();
    nb  = fu.size();
    push_expected();
    for (int i = 0; i < nb; i++) begin
      tr_mode = (fwd && i >= 6) ? 2 : 1;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          s_axis.tvalid = 1'b0;
          @(posedge clk156); #1;
        end
      end
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = beat_data(i);
      s_axis.tkeep  = beat_keep(i);
      s_axis.tlast  = (i == nb - 1);
      s_axis.tuser  = fu[i];
      if (i == rst_at) begin
        tr_mode = 0; sys_rst_n = 1'b0; exp_ok = 0; exp_drop = 0;
        @(negedge clk156);
        chk("rst_mid_tready", s_axis.tready, 0);
        chk("rst_mid_wr_en", wr_en, 0);
        @(posedge clk156); #1;
        @(posedge clk156); #1;
        sys_rst_n = 1'b1; s_axis.tvalid = 1'b0; exp_q.delete(); tr_mode = 1;
        return;
      end
      if (i == stall_at) begin
        full = 1'b1;
        repeat (4) begin
          @(negedge clk156);
          chk("stall_tready", s_axis.tready, 0);
          chk("stall_wr_en", wr_en, 0);
          @(posedge clk156); #1;
        end
        full = 1'b0;
      end
      acc = 1'b0;
      cyc = 0;
      while (!acc) begin
        @(negedge clk156);
        acc = s_axis.tready;
        @(posedge clk156); #1;
        if (++cyc > 200) begin
          chk("accept_timeout", 0, 1);
          s_axis.tvalid = 1'b0;
          return;
        end
      end
    end
    s_axis.tvalid = 1'b0;
    tr_mode = 1;
    if (fwd) exp_ok++; else exp_drop++;
  endtask

  initial begin
    forever begin
      @(posedge clk156); #1;
      if (rand_full) full = ($urandom_range(0, 3) == 0);
    end
  end

  always @(negedge clk156) begin
    if (!sys_rst_n) begin
      chk("rst_tready", s_axis.tready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_din", din, 0);
      chk("rst_ok_cnt", ok_cnt, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
    end else begin
      if (tr_mode == 1) chk("tready_hdr_drop", s_axis.tready, 1);
      if (tr_mode == 2) chk("tready_payload", s_axis.tready, !full);
      if (tr_mode != 0) chk("wr_en_rule", wr_en, (tr_mode == 2) && s_axis.tvalid && s_axis.tready);
      if (wr_en) begin
        n_wr++;
        chk("wr_en_while_full", full, 0);
        if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
        else chk("din", din, exp_q.pop_front());
      end
      chk("ok_cnt", ok_cnt, exp_ok);
      chk("drop_cnt", drop_cnt, exp_drop);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0, kind;
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tkeep = '0;
    s_axis.tlast = 1'b0; s_axis.tuser = 1'b0;
    repeat (3) @(posedge clk156);
    #1;
    sys_rst_n = 1'b1;
    tr_mode = 1;
    @(posedge clk156); #1;

    // Valid frame with 3 payload beats, last one half-filled.
    build_frame(0, 20);
    push_expected();
    chk("t1_model_beats", exp_q.size(), 3);
    chk("t1_model_keep2", exp_q[2][73:66], 8'h0F);
    chk("t1_model_last2", exp_q[2][1], 1);
    chk("t1_model_last0", exp_q[0][1], 0);
    exp_q.delete();
    w0 = n_wr;
    send_frame(-1, -1);
    chk("t1_wr_pulses", n_wr - w0, 3);
    chk("t1_ok_cnt", ok_cnt, 1);

    // Wrong UDP port, broadcast MAC, off-by-one MAC.
    w0 = n_wr;
    build_frame(7, 20); send_frame(-1, -1);
    chk("t2_wr_pulses", n_wr - w0, 0);
    chk("t2_drop_cnt", drop_cnt, 1);
    build_frame(1, 20); send_frame(-1, -1);
    chk("t3_bcast_ok", ok_cnt, 2);
    build_frame(2, 20); send_frame(-1, -1);
    chk("t3_badmac_drop", drop_cnt, 2);

    // Runt ending on header beat 3, then a valid frame back-to-back.
    build_frame(10, 32); send_frame(-1, -1);
    build_frame(0, 24); send_frame(-1, -1);
    chk("t4_drop_cnt", drop_cnt, 3);
    chk("t4_ok_cnt", ok_cnt, 3);

    // FIFO full for 4 cycles mid-payload.
    w0 = n_wr;
    build_frame(0, 40); send_frame(8, -1);
    chk("t5_wr_pulses", n_wr - w0, 5);
    chk("t5_ok_cnt", ok_cnt, 4);

    // Reset during payload, then a clean frame.
    build_frame(0, 32); send_frame(-1, 8);
    chk("t6_ok_after_rst", ok_cnt, 0);
    build_frame(0, 16); send_frame(-1, -1);
    chk("t6_ok_cnt", ok_cnt, 1);
    chk("t6_drop_cnt", drop_cnt, 0);

    rand_full = 1;
    gaps = 1;
    for (int f = 0; f < 200; f++) begin
      kind = $urandom_range(0, 14);
      if (kind > 10) kind = 0;
      if (kind == 10) build_frame(kind, $urandom_range(1, 48));
      else build_frame(kind, $urandom_range(1, 40));
      send_frame(-1, -1);
    end
    rand_full = 0;
    full = 1'b0;
    repeat (3) @(posedge clk156);
    #1;
    chk("leftover_expected", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
